// File: rtl/seq_pattern_tx.sv
// Repeating serial pattern transmitter: sends PATTERN MSB-first `count` times with GAP idle cycles between.
// Optional feature: define SEQ_TX_ABORT_EN to add an abort input that drops the current frame.
module seq_pattern_tx #(
  parameter int unsigned      PAT_W   = 6,
  parameter logic [PAT_W-1:0] PATTERN = 6'b110101,
  parameter int unsigned      GAP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] count,
  output logic       ready,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       done
`ifdef SEQ_TX_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic [IDX_W-1:0] bit_idx, idx_n;
  logic [CNT_W-1:0] gap_cnt, gap_n;
  logic             abort_hit;
  logic             ready_n, tx_bit_n, tx_valid_n, done_n;

`ifdef SEQ_TX_ABORT_EN
  assign abort_hit = abort && ((state == S_SEND) || (state == S_GAP));
`else
  assign abort_hit = 1'b0;
`endif

  // Next-state and counter update; outputs decoded from the upcoming state so the registered copy matches it.
  always_comb begin
    state_n = state;
    rep_n   = rep_cnt;
    idx_n   = bit_idx;
    gap_n   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (start && (count != '0)) begin
          state_n = S_SEND;
          rep_n   = count;
          idx_n   = LAST_IDX;
        end
      end
      S_SEND: begin
        if (bit_idx == '0) begin
          if (rep_cnt == CNT_W'(1)) begin
            state_n = S_DONE;
          end else begin
            rep_n = rep_cnt - CNT_W'(1);
            idx_n = LAST_IDX;
            if (GAP > 0) begin
              state_n = S_GAP;
              gap_n   = GAP_LOAD;
            end
          end
        end else begin
          idx_n = bit_idx - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_n = S_SEND;
        else               gap_n   = gap_cnt - CNT_W'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort wins over every SEND/GAP transition and leaves the counters clean.
    if (abort_hit) begin
      state_n = S_IDLE;
      rep_n   = '0;
      idx_n   = '0;
      gap_n   = '0;
    end
    ready_n    = (state_n == S_IDLE);
    tx_valid_n = (state_n == S_SEND);
    tx_bit_n   = (state_n == S_SEND) && PATTERN[idx_n];
    done_n     = (state_n == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rep_cnt  <= '0;
      bit_idx  <= '0;
      gap_cnt  <= '0;
      ready    <= 1'b1;
      tx_bit   <= 1'b0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      rep_cnt  <= rep_n;
      bit_idx  <= idx_n;
      gap_cnt  <= gap_n;
      ready    <= ready_n;
      tx_bit   <= tx_bit_n;
      tx_valid <= tx_valid_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: expected per-cycle outputs are queued at start acceptance and
// compared every falling edge; an empty queue means the block must look idle.
module tb_seq_pattern_tx;

  localparam int unsigned GAP_CYC = 2;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic       ready;
  logic       tx_bit;
  logic       tx_valid;
  logic       done;
`ifdef SEQ_TX_ABORT_EN
  logic       abort;
`endif

  seq_pattern_tx dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .count    (count),
    .ready    (ready),
    .tx_bit   (tx_bit),
    .tx_valid (tx_valid),
    .done     (done)
`ifdef SEQ_TX_ABORT_EN
    ,
    .abort    (abort)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {ready, tx_valid, tx_bit, done} per cycle.
  logic [3:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         done_cyc = 0;
  int         hits = 0;
  logic [5:0] shreg = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [3:0] e;
    logic [5:0] nxt;
    if (mon_en) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b1000;
      check("out{rdy,vld,bit,done}", {28'b0, ready, tx_valid, tx_bit, done}, {28'b0, e});
      if (done) done_cyc = cyc;
      if (tx_valid) begin
        nxt = {shreg[4:0], tx_bit};
        if (nxt == 6'b110101) hits++;
        shreg = nxt;
      end
    end
  end

  task automatic push_frame(input int n);
    logic [5:0] pat;
    pat = 6'b110101;
    for (int r = 0; r < n; r++) begin
      for (int i = 5; i >= 0; i--) exp_q.push_back({1'b0, 1'b1, pat[i], 1'b0});
      if (r < n - 1) for (int g = 0; g < int'(GAP_CYC); g++) exp_q.push_back(4'b0000);
    end
    exp_q.push_back(4'b0001);
  endtask

  // Called at posedge+1; holds start for one edge, then records what the DUT must emit.
  task automatic start_frame(input logic [3:0] c);
    start = 1'b1;
    count = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    count = 4'($urandom_range(15, 0));
    acc_cyc = cyc;
    if (c != 4'd0) push_frame(int'(c));
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int h0;
    logic [3:0] e;
    rst   = 1'b1;
    start = 1'b0;
    count = 4'd0;
`ifdef SEQ_TX_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    check("reset_out", {28'b0, ready, tx_valid, tx_bit, done}, 32'b1000);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycles(2);

    // single repetition
    start_frame(4'd1);
    drain("drain_c1");
    idle_cycles(2);

    // three repetitions with gaps, done in the 23rd cycle after acceptance
    h0 = hits;
    start_frame(4'd3);
    drain("drain_c3");
    check("pattern_hits", 32'(hits - h0), 32'd3);
    check("done_latency", 32'(done_cyc - acc_cyc + 1), 32'd23);
    idle_cycles(2);

    // count=0 requests are ignored
    repeat (3) start_frame(4'd0);
    idle_cycles(4);

    // restart with another count during SEND is ignored
    start_frame(4'd2);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    count = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain("drain_restart");
    idle_cycles(2);

    // asynchronous reset mid-SEND between edges
    start_frame(4'd2);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst", {28'b0, ready, tx_valid, tx_bit, done}, 32'b1000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_cycles(6);

`ifdef SEQ_TX_ABORT_EN
    // abort on the third bit, then a clean full frame
    start_frame(4'd2);
    @(posedge clk);
    @(posedge clk);
    #1;
    abort = 1'b1;
    e = exp_q[0];
    exp_q.delete();
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    abort = 1'b0;
    idle_cycles(3);
    start_frame(4'd1);
    drain("drain_after_abort");
    idle_cycles(2);
`endif

    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
